pipe_fetch: RTL and testbench

Parametrised instruction-fetch stage for the five-stage pipelined CPU core. It replaces the single-cycle PC/next-PC logic with three pieces: a PC register, an IF/ID pipeline register, and stall/flush handling. It drives the IROM address combinationally from the PC and captures the returned instruction into IF/ID. It accepts redirects from EX (branch mispredict, JALR) and optionally predicts JAL and backward branches at fetch.

---
 rtl/pipe_fetch.sv | 110 +++++++++++
 tb/tb_pipe_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction-fetch stage made of a PC register, an IF/ID pipeline
// register, and the stall/flush handling between them.
//
// Build option: define STATIC_BP_EN to predict JAL and backward conditional
// branches as taken at fetch. Without it, the next PC is always pc+4 and every
// control transfer is resolved by a redirect from EX.
//
// Ports:
//   cpu_clk, cpu_rst    clock; synchronous active-high reset
//   inst_addr           IROM word address, combinational from the PC register
//   inst                IROM read data, valid in the same cycle as inst_addr
//   stall               hold the PC and IF/ID
//   redirect_valid/_pc  flush IF/ID and refetch from redirect_pc (bits [1:0] ignored)
//   id_*                IF/ID contents: valid, instruction, PC, PC+4, predicted-taken
//   perf_fetch_cnt      instructions delivered into IF/ID (saturating)
//   perf_flush_cnt      redirects accepted (saturating)
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IADDR_W  = 14,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  output logic [IADDR_W-1:0] inst_addr,
  input  logic [31:0]        inst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               id_pred_taken,
  output logic [CNT_W-1:0]   perf_fetch_cnt,
  output logic [CNT_W-1:0]   perf_flush_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] redirect_target;

  assign inst_addr       = pc[IADDR_W+1:2];
  assign pc_plus4        = pc + 32'd4;
  // Masking rather than slicing keeps the ignored low bits explicit.
  assign redirect_target = redirect_pc & ~32'd3;

`ifdef STATIC_BP_EN
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        is_jal;
  logic        is_bwd_branch;

  always_comb begin
    j_imm         = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm         = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    is_jal        = (inst[6:0] == 7'b1101111);
    // Sign bit of the B-immediate set means a backward branch (loop closer).
    is_bwd_branch = (inst[6:0] == 7'b1100011) && inst[31];
    pred_taken    = is_jal || is_bwd_branch;
    if (is_jal) begin
      next_pc = pc + j_imm;
    end else if (is_bwd_branch) begin
      next_pc = pc + b_imm;
    end else begin
      next_pc = pc_plus4;
    end
  end
`else
  assign pred_taken = 1'b0;
  assign next_pc    = pc_plus4;
`endif

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc             <= RESET_PC;
      id_valid       <= 1'b0;
      id_inst        <= NOP;
      id_pc          <= '0;
      id_pc4         <= '0;
      id_pred_taken  <= 1'b0;
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (redirect_valid) begin
      // Flush wins over stall; id_pc/id_pc4 are left as they were since the
      // bubble is marked invalid.
      pc            <= redirect_target;
      id_valid      <= 1'b0;
      id_inst       <= NOP;
      id_pred_taken <= 1'b0;
      if (perf_flush_cnt != '1) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end else if (!stall) begin
      pc            <= next_pc;
      id_valid      <= 1'b1;
      id_inst       <= inst;
      id_pc         <= pc;
      id_pc4        <= pc_plus4;
      id_pred_taken <= pred_taken;
      if (perf_fetch_cnt != '1) begin
        perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// Scoreboard bench for pipe_fetch. A reference model advances once per rising
// edge from the same inputs the DUT sees and queues the expected post-edge
// state; a monitor on the falling edge pops and compares every output.
module tb_pipe_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0010;
  localparam int unsigned IADDR_W  = 8;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned DEPTH    = 1 << IADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               cpu_clk = 1'b0;
  logic               cpu_rst = 1'b1;
  logic [IADDR_W-1:0] inst_addr;
  logic [31:0]        inst;
  logic               stall = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [31:0]        redirect_pc = '0;
  logic               id_valid;
  logic [31:0]        id_inst;
  logic [31:0]        id_pc;
  logic [31:0]        id_pc4;
  logic               id_pred_taken;
  logic [CNT_W-1:0]   perf_fetch_cnt;
  logic [CNT_W-1:0]   perf_flush_cnt;

  logic [31:0] rom [DEPTH];
  assign inst = rom[inst_addr];

  pipe_fetch #(.RESET_PC(RESET_PC), .IADDR_W(IADDR_W), .CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_addr(inst_addr), .inst(inst),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_pred_taken(id_pred_taken), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [IADDR_W-1:0] addr;
    logic               valid;
    logic [31:0]        inst;
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic               pt;
    int                 fcnt;
    int                 flcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   model_on = 1'b0;

  // Reference model state (integers; counters saturate by comparison)
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;
  logic        m_pt;
  int          m_fcnt;
  int          m_flcnt;

  // Prediction from the instruction encoding using signed integer offsets.
  function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                  output logic [31:0] npc, output logic taken);
    int off;
    npc   = pc + 32'd4;
    taken = 1'b0;
`ifdef STATIC_BP_EN
    if (w[6:0] == 7'h6F) begin
      off = (int'(w[30:21]) * 2) + (int'(w[20]) * 2048) + (int'(w[19:12]) * 4096);
      if (w[31]) off = off - (1 << 20);
      npc   = pc + 32'(off);
      taken = 1'b1;
    end else if (w[6:0] == 7'h63 && w[31]) begin
      off = (int'(w[11:8]) * 2) + (int'(w[30:25]) * 32) + (int'(w[7]) * 2048) - 4096;
      npc   = pc + 32'(off);
      taken = 1'b1;
    end
`endif
  endfunction

  always @(posedge cpu_clk) begin
    logic [31:0] npc;
    logic        tk;
    logic [31:0] w;
    exp_t        e;
    if (cpu_rst) begin
      m_pc = RESET_PC; m_valid = 1'b0; m_inst = 32'h13; m_idpc = '0;
      m_idpc4 = '0; m_pt = 1'b0; m_fcnt = 0; m_flcnt = 0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_valid = 1'b0; m_inst = 32'h13; m_pt = 1'b0;
      if (m_flcnt < int'(CNT_MAX)) m_flcnt++;
    end else if (!stall) begin
      w = rom[(m_pc / 4) % DEPTH];
      predict(m_pc, w, npc, tk);
      m_valid = 1'b1; m_inst = w; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4; m_pt = tk;
      m_pc = npc;
      if (m_fcnt < int'(CNT_MAX)) m_fcnt++;
    end
    e.addr = IADDR_W'((m_pc / 4) % DEPTH);
    e.valid = m_valid; e.inst = m_inst; e.pc = m_idpc; e.pc4 = m_idpc4;
    e.pt = m_pt; e.fcnt = m_fcnt; e.flcnt = m_flcnt;
    exp_q.push_back(e);
    model_on = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  always @(negedge cpu_clk) begin
    exp_t e;
    if (model_on) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: got 0 entries expected >=1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("inst_addr", 32'(inst_addr), 32'(e.addr));
        chk("id_valid", 32'(id_valid), 32'(e.valid));
        chk("id_inst", id_inst, e.inst);
        chk("id_pc", id_pc, e.pc);
        chk("id_pc4", id_pc4, e.pc4);
        chk("id_pred_taken", 32'(id_pred_taken), 32'(e.pt));
        chk("perf_fetch_cnt", 32'(perf_fetch_cnt), 32'(e.fcnt));
        chk("perf_flush_cnt", 32'(perf_flush_cnt), 32'(e.flcnt));
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    cpu_rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      case ($urandom_range(0, 3))
        0: rom[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'h6F};
        1: rom[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'h63};
        2: rom[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'h13};
        default: rom[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'h67};
      endcase
    end
    rom[4] = 32'h0000_0013;   // pc 0x10: plain fetch after reset
    rom[5] = 32'h0000_0013;
    rom[6] = 32'h0000_0013;
    rom[7] = 32'h0000_0013;
    rom[8] = 32'hFE00_0EE3;   // beq x0,x0,-4 at pc 0x20
    rom[0] = 32'h0010_006F;   // jal x0,+0x800 (reached via 0xFFFF_F800)
    #1;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h0000_0103);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0020);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_F800);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0055);
    cyc(1, 0, 1, 32'h0000_0200);
    repeat (80) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0010);
    repeat (400) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 15) == 0) ? 32'hFFFF_F800 + $urandom_range(0, 15)
                                        : $urandom_range(0, 32'h3FF);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, rp);
    end
    cyc(0, 0, 0, 0);
    @(negedge cpu_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
